multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Control unit for a multicycle MIPS-style datapath. A six-state FSM
//   (FETCH, DECODE, EXEC, MEM, WB, TRAP) sequences each instruction.
//   Outputs are combinational from the current state, opcode, zero and
//   mem_ready. Unknown opcodes park the FSM in TRAP with a sticky flag
//   until reset.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   opcode[5:0]              IR[31:26], stable from DECODE back to FETCH
//   zero                     ALU zero flag (branch resolution)
//   mem_ready                memory access completes this cycle
//   pc_write, ir_write       PC / IR load enables
//   pc_src[1:0]              00 PC+4, 01 branch target, 10 jump target
//   read_mem, write_mem      memory strobes
//   write_reg                register file write strobe
//   mux_write_rt_rd_cnst     destination select: 00 rt, 01 rd, 10 $31
//   mux_alu_src_reg_imm      ALU B operand: 0 register, 1 immediate
//   alu_op[ALUOP_W-1:0]      ALU operation code
//   mux_load_byte_half_word  load width: 00 byte, 01 half, 10 word
//   mux_store_size           store width: 00 byte, 01 half, 10 word
//   mux_reg_src_alu_mem_pc   write-back source: 00 mem, 01 ALU, 10 PC
//   illegal_op               sticky illegal-opcode flag
//   state[2:0]               current FSM state
//   instr_count[CNT_W-1:0]   retired instruction counter (wraps)
module multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int CNT_W       = 16,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic [1:0]         pc_src,
  output logic               read_mem,
  output logic               write_mem,
  output logic               write_reg,
  output logic [1:0]         mux_write_rt_rd_cnst,
  output logic               mux_alu_src_reg_imm,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         mux_load_byte_half_word,
  output logic [1:0]         mux_store_size,
  output logic [1:0]         mux_reg_src_alu_mem_pc,
  output logic               illegal_op,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instr_count
);

  if (ALUOP_W < 4) begin : g_bad_aluop_w
    $error("multicycle_control: ALUOP_W must be at least 4");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t             state_q, state_d;
  logic               illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;

  logic       mem_rdy;
  logic       is_legal;
  logic       is_load;
  logic       is_store;
  logic [3:0] alu_op4;
  logic       retire;

  // With the handshake disabled every access completes in one cycle.
  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Opcode classification.
  always_comb begin
    is_legal = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OP_R, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: is_legal = 1'b1;
      OP_LW, OP_LHU, OP_LBU:        is_load  = 1'b1;
      OP_SW, OP_SH, OP_SB:          is_store = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d                 = state_q;
    pc_write                = 1'b0;
    ir_write                = 1'b0;
    pc_src                  = 2'b00;
    read_mem                = 1'b0;
    write_mem               = 1'b0;
    write_reg               = 1'b0;
    mux_write_rt_rd_cnst    = 2'b00;
    mux_alu_src_reg_imm     = 1'b0;
    alu_op4                 = 4'b0010;
    mux_load_byte_half_word = 2'b00;
    mux_store_size          = 2'b00;
    mux_reg_src_alu_mem_pc  = 2'b01;

    case (state_q)
      S_FETCH: begin
        read_mem = 1'b1;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'b00;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!is_legal) begin
          state_d = S_TRAP;
        end else if (opcode == OP_J) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_FETCH;
        end else if (opcode == OP_JAL) begin
          pc_write               = 1'b1;
          pc_src                 = 2'b10;
          write_reg              = 1'b1;
          mux_write_rt_rd_cnst   = 2'b10;
          mux_reg_src_alu_mem_pc = 2'b10;
          state_d                = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op4 = 4'b0010;
            state_d = S_WB;
          end
          OP_ADDI, OP_ADDIU: begin
            alu_op4             = 4'b0000;
            mux_alu_src_reg_imm = 1'b1;
            state_d             = S_WB;
          end
          OP_ANDI: begin
            alu_op4             = 4'b0011;
            mux_alu_src_reg_imm = 1'b1;
            state_d             = S_WB;
          end
          OP_ORI: begin
            alu_op4             = 4'b0101;
            mux_alu_src_reg_imm = 1'b1;
            state_d             = S_WB;
          end
          OP_LW, OP_LHU, OP_LBU, OP_SW, OP_SH, OP_SB: begin
            alu_op4             = 4'b0000;
            mux_alu_src_reg_imm = 1'b1;
            state_d             = S_MEM;
          end
          OP_BEQ: begin
            alu_op4  = 4'b0001;
            pc_src   = 2'b01;
            pc_write = zero;
            state_d  = S_FETCH;
          end
          OP_BNE: begin
            alu_op4  = 4'b0100;
            pc_src   = 2'b01;
            pc_write = ~zero;
            state_d  = S_FETCH;
          end
          // Opcode changed under us; abandon the instruction.
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (is_load) begin
          read_mem = 1'b1;
          if (mem_rdy) state_d = S_WB;
        end else if (is_store) begin
          write_mem = 1'b1;
          case (opcode)
            OP_SW:   mux_store_size = 2'b10;
            OP_SH:   mux_store_size = 2'b01;
            default: mux_store_size = 2'b00;
          endcase
          if (mem_rdy) state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        write_reg = 1'b1;
        state_d   = S_FETCH;
        case (opcode)
          OP_R: mux_write_rt_rd_cnst = 2'b01;
          OP_LW: begin
            mux_reg_src_alu_mem_pc  = 2'b00;
            mux_load_byte_half_word = 2'b10;
          end
          OP_LHU: begin
            mux_reg_src_alu_mem_pc  = 2'b00;
            mux_load_byte_half_word = 2'b01;
          end
          OP_LBU: begin
            mux_reg_src_alu_mem_pc  = 2'b00;
            mux_load_byte_half_word = 2'b00;
          end
          default: mux_write_rt_rd_cnst = 2'b00;
        endcase
      end

      S_TRAP: state_d = S_TRAP;

      // Unused encodings recover to FETCH.
      default: state_d = S_FETCH;
    endcase

    // Strobes are gated while reset is held so nothing is written
    // during a reset that lands mid-access.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      write_reg = 1'b0;
      write_mem = 1'b0;
      read_mem  = 1'b0;
    end
  end

  // An instruction retires whenever a working state hands back to FETCH.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_DECODE, S_EXEC, S_MEM, S_WB: retire = 1'b1;
        default:                       retire = 1'b0;
      endcase
    end
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) instr_count_d = instr_count_q + CNT_W'(1);
    illegal_op_d = illegal_op_q;
    if (state_q == S_DECODE && !is_legal) illegal_op_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      illegal_op_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_op_q  <= illegal_op_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    alu_op      = '0;
    alu_op[3:0] = alu_op4;
  end

  assign state       = state_q;
  assign illegal_op  = illegal_op_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Stimulus tasks push one expected
// output record per clock cycle; a negedge monitor pops and compares.
// A second instance with CNT_W=2 shares the stimulus to exercise wrap.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        pc_write, ir_write, read_mem, write_mem, write_reg;
  logic [1:0]  pc_src, dest_sel, ld_sel, st_sel, src_sel;
  logic        alu_src, illegal_op;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic        w2_pc_write, w2_ir_write, w2_read_mem, w2_write_mem, w2_write_reg;
  logic [1:0]  w2_pc_src, w2_dest_sel, w2_ld_sel, w2_st_sel, w2_src_sel;
  logic        w2_alu_src, w2_illegal_op;
  logic [3:0]  w2_alu_op;
  logic [2:0]  w2_state;
  logic [1:0]  w2_instr_count;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .pc_src(pc_src),
    .read_mem(read_mem), .write_mem(write_mem), .write_reg(write_reg),
    .mux_write_rt_rd_cnst(dest_sel), .mux_alu_src_reg_imm(alu_src),
    .alu_op(alu_op), .mux_load_byte_half_word(ld_sel),
    .mux_store_size(st_sel), .mux_reg_src_alu_mem_pc(src_sel),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(w2_pc_write), .ir_write(w2_ir_write), .pc_src(w2_pc_src),
    .read_mem(w2_read_mem), .write_mem(w2_write_mem), .write_reg(w2_write_reg),
    .mux_write_rt_rd_cnst(w2_dest_sel), .mux_alu_src_reg_imm(w2_alu_src),
    .alu_op(w2_alu_op), .mux_load_byte_half_word(w2_ld_sel),
    .mux_store_size(w2_st_sel), .mux_reg_src_alu_mem_pc(w2_src_sel),
    .illegal_op(w2_illegal_op), .state(w2_state), .instr_count(w2_instr_count)
  );

  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                         MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, irw, rd, wr, wreg;
    logic [1:0]  pcsrc, dest;
    logic        asrc;
    logic [3:0]  aop;
    logic [1:0]  ld, stsz, rsrc;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;
  logic exp_ill  = 1'b0;
  int   fetch_waits = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is one observed output.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("state", 32'(state), 32'(cur.st));
      chk("strobes", 32'({pc_write, ir_write, read_mem, write_mem, write_reg}),
          32'({cur.pcw, cur.irw, cur.rd, cur.wr, cur.wreg}));
      chk("pc_src", 32'(pc_src), 32'(cur.pcsrc));
      chk("dest", 32'(dest_sel), 32'(cur.dest));
      chk("alu_src", 32'(alu_src), 32'(cur.asrc));
      chk("alu_op", 32'(alu_op), 32'(cur.aop));
      chk("load_w", 32'(ld_sel), 32'(cur.ld));
      chk("store_w", 32'(st_sel), 32'(cur.stsz));
      chk("reg_src", 32'(src_sel), 32'(cur.rsrc));
      chk("illegal", 32'(illegal_op), 32'(cur.ill));
      chk("count", 32'(instr_count), 32'(cur.cnt));
      chk("w2_state", 32'(w2_state), 32'(cur.st));
      chk("w2_count", 32'(w2_instr_count), 32'(cur.cnt[1:0]));
    end
    cyc++;
  end

  function automatic exp_t mk(logic [2:0] st);
    exp_t e;
    e = '0;
    e.st   = st;
    e.aop  = 4'b0010;
    e.rsrc = 2'b01;
    e.ill  = exp_ill;
    e.cnt  = 16'(exp_cnt);
    return e;
  endfunction

  task automatic step(exp_t e, logic [5:0] op, logic z, logic mr, logic r);
    opcode = op; zero = z; mem_ready = mr; rst = r;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic retire(string name);
    exp_cnt = (exp_cnt + 1) & 16'hffff;
    $display("txn %s retired, expected count %0d", name, exp_cnt);
  endtask

  task automatic do_fetch(logic [5:0] op);
    exp_t e;
    for (int i = 0; i < fetch_waits; i++) begin
      e = mk(FETCH); e.rd = 1'b1;
      step(e, op, 1'b0, 1'b0, 1'b0);
    end
    e = mk(FETCH); e.rd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    step(e, op, 1'b0, 1'b1, 1'b0);
    step(mk(DECODE), op, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_alu(string name, logic [5:0] op, logic [3:0] aop, logic imm);
    exp_t e;
    do_fetch(op);
    e = mk(EXEC); e.aop = aop; e.asrc = imm;
    step(e, op, 1'b0, 1'b1, 1'b0);
    e = mk(WB); e.wreg = 1'b1; e.dest = imm ? 2'b00 : 2'b01;
    step(e, op, 1'b0, 1'b1, 1'b0);
    retire(name);
  endtask

  task automatic do_load(string name, logic [5:0] op, logic [1:0] width, int waits);
    exp_t e;
    do_fetch(op);
    e = mk(EXEC); e.aop = 4'b0000; e.asrc = 1'b1;
    step(e, op, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      e = mk(MEM); e.rd = 1'b1;
      step(e, op, 1'b0, (i == waits), 1'b0);
    end
    e = mk(WB); e.wreg = 1'b1; e.rsrc = 2'b00; e.ld = width;
    step(e, op, 1'b0, 1'b1, 1'b0);
    retire(name);
  endtask

  task automatic do_store(string name, logic [5:0] op, logic [1:0] size, int waits);
    exp_t e;
    do_fetch(op);
    e = mk(EXEC); e.aop = 4'b0000; e.asrc = 1'b1;
    step(e, op, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      e = mk(MEM); e.wr = 1'b1; e.stsz = size;
      step(e, op, 1'b0, (i == waits), 1'b0);
    end
    retire(name);
  endtask

  task automatic do_branch(string name, logic [5:0] op, logic [3:0] aop, logic z, logic taken);
    exp_t e;
    do_fetch(op);
    e = mk(EXEC); e.aop = aop; e.pcsrc = 2'b01; e.pcw = taken;
    step(e, op, z, 1'b1, 1'b0);
    retire(name);
  endtask

  task automatic do_jump(string name, logic [5:0] op, logic link);
    exp_t e;
    fetch_waits = 0;
    e = mk(FETCH); e.rd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    step(e, op, 1'b0, 1'b1, 1'b0);
    e = mk(DECODE); e.pcw = 1'b1; e.pcsrc = 2'b10;
    if (link) begin e.wreg = 1'b1; e.dest = 2'b10; e.rsrc = 2'b10; end
    step(e, op, 1'b0, 1'b1, 1'b0);
    retire(name);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // Reset held: FETCH with every strobe gated off.
    step(mk(FETCH), 6'b001000, 1'b0, 1'b1, 1'b1);
    $display("txn reset, expected count 0");

    fetch_waits = 0;
    do_alu("ADDI", 6'b001000, 4'b0000, 1'b1);
    do_load("LHU", 6'b100101, 2'b01, 2);
    do_branch("BEQ nt", 6'b000100, 4'b0001, 1'b0, 1'b0);
    do_branch("BNE t", 6'b000101, 4'b0100, 1'b0, 1'b1);
    do_jump("JAL", 6'b000011, 1'b1);
    do_jump("J", 6'b000010, 1'b0);
    fetch_waits = 1;
    do_load("LW", 6'b100011, 2'b10, 0);
    do_load("LBU", 6'b100100, 2'b00, 1);
    fetch_waits = 0;
    do_store("SW", 6'b101011, 2'b10, 0);
    do_store("SH", 6'b101001, 2'b01, 1);
    do_store("SB", 6'b101000, 2'b00, 0);
    do_branch("BEQ t", 6'b000100, 4'b0001, 1'b1, 1'b1);
    do_branch("BNE nt", 6'b000101, 4'b0100, 1'b1, 1'b0);

    // Reset lands in MEM during SW: write_mem gated, store width still shown.
    do_fetch(6'b101011);
    e = mk(EXEC); e.aop = 4'b0000; e.asrc = 1'b1;
    step(e, 6'b101011, 1'b0, 1'b1, 1'b0);
    e = mk(MEM); e.stsz = 2'b10;
    step(e, 6'b101011, 1'b0, 1'b1, 1'b1);
    exp_cnt = 0;
    $display("txn SW interrupted by reset, expected count 0");

    // Five ALU ops: the 2-bit counter reads 1,2,3,0,1.
    do_alu("R", 6'b000000, 4'b0010, 1'b0);
    do_alu("ADDIU", 6'b001001, 4'b0000, 1'b1);
    do_alu("ANDI", 6'b001100, 4'b0011, 1'b1);
    do_alu("ORI", 6'b001101, 4'b0101, 1'b1);
    do_alu("ADDI", 6'b001000, 4'b0000, 1'b1);

    // Illegal opcode traps; flag is sticky and strobes stay low.
    do_fetch(6'b111111);
    exp_ill = 1'b1;
    for (int i = 0; i < 10; i++)
      step(mk(TRAP), 6'(i * 7), i[0], i[1], 1'b0);
    step(mk(TRAP), 6'b111111, 1'b0, 1'b1, 1'b1);
    exp_ill = 1'b0;
    exp_cnt = 0;
    $display("txn TRAP cleared by reset");
    do_alu("ADDI", 6'b001000, 4'b0000, 1'b1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
